dpram_block_copier: RTL and testbench

- Single-clock copy engine sitting directly upstream of dual_port_RAM; drives both RAM ports as the RAM's only master.
- On a start command it reads a contiguous block of words through port A and writes it to a second address range through port B.
- Reads and writes are pipelined at one word per cycle.
- Used for buffer relocation and for exercising simultaneous A-read/B-write traffic in the memory environment.

---
 rtl/dpram_block_copier.sv | 186 ++++++++++++++++++
 tb/tb_dpram_block_copier.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_block_copier.sv
// rtl/dpram_block_copier.sv - pipelined block copy engine driving both ports of a dual-port RAM
`timescale 1ns/1ps

module dpram_block_copier #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              a_wr,
  output logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] a_din,
  input  logic [DATA_W-1:0] a_dout,
  output logic              b_wr,
  output logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_din,
  input  logic [DATA_W-1:0] b_dout
);

  localparam int DEPTH = 2 ** ADDR_W;
  // Two spare bits so src+len and dst+len never overflow during the range checks.
  localparam int EW = ADDR_W + 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  // Outstanding-read tracker: stage i holds reads issued i+1 cycles ago.
  logic [RD_LAT-1:0]             vld_q, vld_d;
  logic [RD_LAT-1:0][ADDR_W-1:0] idx_q, idx_d;

  logic              b_wr_q, b_wr_d;
  logic [ADDR_W-1:0] b_addr_q, b_addr_d;
  logic [DATA_W-1:0] b_din_q, b_din_d;

  logic [EW-1:0] src_e, dst_e, len_e, depth_e;
  logic          illegal;
  logic          unused_b_dout;

  assign src_e   = {2'b00, src_q};
  assign dst_e   = {2'b00, dst_q};
  assign len_e   = {1'b0, len_q};
  assign depth_e = EW'(DEPTH);

  // Ranges may not wrap past the top of the RAM and may not share any word.
  assign illegal = (len_q == '0) ||
                   (len_e > depth_e) ||
                   (src_e + len_e > depth_e) ||
                   (dst_e + len_e > depth_e) ||
                   ((src_e < dst_e + len_e) && (dst_e < src_e + len_e));

  // Command FSM: latch, validate, stream reads, wait for the write tail, report.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    rd_cnt_d = rd_cnt_q;
    a_addr_d = a_addr_q;
    error_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = len;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (illegal) begin
          error_d = 1'b1;
          state_d = S_FINISH;
        end else begin
          a_addr_d = src_q;
          rd_cnt_d = '0;
          state_d  = S_READ;
        end
      end
      S_READ: begin
        if (rd_cnt_q == len_q - 1'b1) begin
          state_d = S_DRAIN;
        end else begin
          a_addr_d = a_addr_q + 1'b1;
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // The last write is on the bus once nothing is left in flight.
        if (b_wr_q && (vld_q == '0)) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_CHECK) || (state_d == S_READ) || (state_d == S_DRAIN);
    done_d = (state_d == S_FINISH);
  end

  // Read-tracking shift register and write-port staging.
  always_comb begin
    vld_d    = '0;
    idx_d    = '0;
    vld_d[0] = (state_q == S_READ);
    idx_d[0] = rd_cnt_q[ADDR_W-1:0];
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
    b_wr_d   = vld_q[RD_LAT-1];
    b_addr_d = b_addr_q;
    b_din_d  = b_din_q;
    if (vld_q[RD_LAT-1]) begin
      b_addr_d = dst_q + idx_q[RD_LAT-1];
      b_din_d  = a_dout;
    end
  end

  // State and output registers; reset clears everything at once so no write escapes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      rd_cnt_q <= '0;
      a_addr_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      vld_q    <= '0;
      idx_q    <= '0;
      b_wr_q   <= 1'b0;
      b_addr_q <= '0;
      b_din_q  <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      rd_cnt_q <= rd_cnt_d;
      a_addr_q <= a_addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      vld_q    <= vld_d;
      idx_q    <= idx_d;
      b_wr_q   <= b_wr_d;
      b_addr_q <= b_addr_d;
      b_din_q  <= b_din_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign a_wr          = 1'b0;
  assign a_addr        = a_addr_q;
  assign a_din         = '0;
  assign b_wr          = b_wr_q;
  assign b_addr        = b_addr_q;
  assign b_din         = b_din_q;
  assign unused_b_dout = ^b_dout;

endmodule

// File: tb/tb_dpram_block_copier.sv
// tb/tb_dpram_block_copier.sv - directed self-checking bench for dpram_block_copier
`timescale 1ns/1ps

module tb_dpram_block_copier;

  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start0, start1;
  logic [AW-1:0] src, dst;
  logic [AW:0]   len;
  logic [DW-1:0] b_dout_tie;

  logic          busy0, done0, error0, a_wr0, b_wr0;
  logic [AW-1:0] a_addr0, b_addr0;
  logic [DW-1:0] a_din0, a_dout0, b_din0;
  logic          busy1, done1, error1, a_wr1, b_wr1;
  logic [AW-1:0] a_addr1, b_addr1;
  logic [DW-1:0] a_din1, a_dout1, b_din1;

  dpram_block_copier #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .src_addr(src), .dst_addr(dst), .len(len),
    .busy(busy0), .done(done0), .error(error0),
    .a_wr(a_wr0), .a_addr(a_addr0), .a_din(a_din0), .a_dout(a_dout0),
    .b_wr(b_wr0), .b_addr(b_addr0), .b_din(b_din0), .b_dout(b_dout_tie)
  );

  dpram_block_copier #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .src_addr(src), .dst_addr(dst), .len(len),
    .busy(busy1), .done(done1), .error(error1),
    .a_wr(a_wr1), .a_addr(a_addr1), .a_din(a_din1), .a_dout(a_dout1),
    .b_wr(b_wr1), .b_addr(b_addr1), .b_din(b_din1), .b_dout(b_dout_tie)
  );

  // RAM models: mem0 has 1-cycle read latency, mem1 has 3.
  logic [DW-1:0]        mem0 [16];
  logic [DW-1:0]        mem1 [16];
  logic [DW-1:0]        rp0;
  logic [2:0][DW-1:0]   rp1;
  logic                 tb_we;
  logic [AW-1:0]        tb_addr;
  logic [DW-1:0]        tb_data;

  always @(posedge clk) begin
    rp0 <= mem0[a_addr0];
    rp1 <= {rp1[1:0], mem1[a_addr1]};
    if (tb_we) begin
      mem0[tb_addr] <= tb_data;
      mem1[tb_addr] <= tb_data;
    end else begin
      if (b_wr0) mem0[b_addr0] <= b_din0;
      if (b_wr1) mem1[b_addr1] <= b_din1;
    end
  end
  assign a_dout0    = rp0;
  assign a_dout1    = rp1[2];
  assign b_dout_tie = '0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-cycle logs, index = cycle number after the start edge.
  logic          busy_l0 [32], done_l0 [32], err_l0 [32], awr_l0 [32], bwr_l0 [32];
  logic [AW-1:0] aaddr_l0 [32], baddr_l0 [32];
  logic [DW-1:0] bdin_l0 [32];
  logic          busy_l1 [32], done_l1 [32], err_l1 [32], bwr_l1 [32], awr_l1 [32];
  logic [AW-1:0] baddr_l1 [32];
  logic [DW-1:0] bdin_l1 [32];
  int            inj_cyc = 0;
  logic [DW-1:0] t1_dat [4];

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic run(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] l,
                     input bit on1, input int n);
    src = s; dst = d; len = l;
    start0 = !on1; start1 = on1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    for (int c = 1; c <= n; c++) begin
      busy_l0[c] = busy0; done_l0[c] = done0; err_l0[c] = error0; awr_l0[c] = a_wr0;
      bwr_l0[c] = b_wr0; aaddr_l0[c] = a_addr0; baddr_l0[c] = b_addr0; bdin_l0[c] = b_din0;
      busy_l1[c] = busy1; done_l1[c] = done1; err_l1[c] = error1; bwr_l1[c] = b_wr1;
      awr_l1[c] = a_wr1; baddr_l1[c] = b_addr1; bdin_l1[c] = b_din1;
      if (c == inj_cyc) begin
        start0 = 1'b1; src = 4'd0; dst = 4'd14; len = 5'd2;
      end else begin
        start0 = 1'b0;
      end
      @(posedge clk); #1;
    end
    start0 = 1'b0;
  endtask

  // Legal copy on the RD_LAT=1 instance: busy 1..l+3, reads 2..l+1, writes 4..l+3, done l+4.
  task automatic chk_legal(input string tag, input int s, input int d, input int l, input int n);
    for (int c = 1; c <= n; c++) begin
      check($sformatf("%s busy c%0d", tag, c), busy_l0[c], (c <= l + 3));
      check($sformatf("%s done c%0d", tag, c), done_l0[c], (c == l + 4));
      check($sformatf("%s a_wr c%0d", tag, c), awr_l0[c], 0);
      check($sformatf("%s b_wr c%0d", tag, c), bwr_l0[c], (c >= 4 && c <= l + 3));
      if (c >= 2 && c <= l + 1)
        check($sformatf("%s a_addr c%0d", tag, c), aaddr_l0[c], s + c - 2);
      if (c >= 4 && c <= l + 3)
        check($sformatf("%s b_addr c%0d", tag, c), baddr_l0[c], d + c - 4);
      if (c == l + 4)
        check($sformatf("%s error c%0d", tag, c), err_l0[c], 0);
    end
  endtask

  // Rejected command: busy in cycle 1 only, done and error in cycle 2, no writes.
  task automatic chk_reject(input string tag, input int n);
    for (int c = 1; c <= n; c++) begin
      check($sformatf("%s busy c%0d", tag, c), busy_l0[c], (c == 1));
      check($sformatf("%s done c%0d", tag, c), done_l0[c], (c == 2));
      check($sformatf("%s error c%0d", tag, c), err_l0[c], (c == 2));
      check($sformatf("%s a_wr c%0d", tag, c), awr_l0[c], 0);
      check($sformatf("%s b_wr c%0d", tag, c), bwr_l0[c], 0);
    end
  endtask

  initial begin
    t1_dat[0] = 8'd11; t1_dat[1] = 8'd22; t1_dat[2] = 8'd33; t1_dat[3] = 8'd44;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    src = '0; dst = '0; len = '0;
    tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", busy0, 0);
    check("rst done", done0, 0);
    check("rst error", error0, 0);
    check("rst a_wr", a_wr0, 0);
    check("rst a_addr", a_addr0, 0);
    check("rst a_din", a_din0, 0);
    check("rst b_wr", b_wr0, 0);
    check("rst b_addr", b_addr0, 0);
    check("rst b_din", b_din0, 0);
    check("rst busy1", busy1, 0);
    check("rst b_wr1", b_wr1, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) preload(4'(i), 8'hA0 + 8'(i));
    for (int i = 0; i < 4; i++) preload(4'(i), t1_dat[i]);

    // Basic copy 0..3 -> 8..11
    run(4'd0, 4'd8, 5'd4, 1'b0, 10);
    chk_legal("t1", 0, 8, 4, 10);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1 b_din k%0d", k), bdin_l0[4 + k], t1_dat[k]);
      check($sformatf("t1 mem k%0d", k), mem0[8 + k], t1_dat[k]);
    end

    // Full-size self overlap, zero length, destination overrun
    run(4'd0, 4'd0, 5'd16, 1'b0, 5);
    chk_reject("t2", 5);
    check("t2 mem0", mem0[0], 8'd11);
    run(4'd0, 4'd4, 5'd0, 1'b0, 4);
    chk_reject("len0", 4);
    run(4'd0, 4'd13, 5'd4, 1'b0, 4);
    chk_reject("dstov", 4);

    // Source overrun rejected, then the in-range variant copies 12..15 -> 0..3
    run(4'd12, 4'd0, 5'd5, 1'b0, 4);
    chk_reject("t3a", 4);
    for (int k = 0; k < 4; k++) check($sformatf("t3a mem k%0d", k), mem0[k], t1_dat[k]);
    run(4'd12, 4'd0, 5'd4, 1'b0, 9);
    chk_legal("t3b", 12, 0, 4, 9);
    for (int k = 0; k < 4; k++) check($sformatf("t3b mem k%0d", k), mem0[k], 8'hAC + 8'(k));

    // Second start mid-copy must be ignored
    inj_cyc = 4;
    run(4'd0, 4'd8, 5'd8, 1'b0, 14);
    inj_cyc = 0;
    chk_legal("t4", 0, 8, 8, 14);
    for (int k = 0; k < 8; k++)
      check($sformatf("t4 mem k%0d", k), mem0[8 + k], (k < 4) ? 8'hAC + 8'(k) : 8'hA0 + 8'(k));

    // Reset during the third write
    for (int k = 8; k < 16; k++) preload(4'(k), 8'h00);
    src = 4'd0; dst = 4'd8; len = 5'd8; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("t5 b_wr pre-rst", b_wr0, 1);
    check("t5 b_addr pre-rst", b_addr0, 10);
    rst_n = 1'b0;
    #1;
    check("t5 busy async", busy0, 0);
    check("t5 b_wr async", b_wr0, 0);
    check("t5 done async", done0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5 mem8", mem0[8], 8'hAC);
    check("t5 mem9", mem0[9], 8'hAD);
    check("t5 mem10", mem0[10], 8'h00);
    check("t5 mem15", mem0[15], 8'h00);
    run(4'd0, 4'd8, 5'd8, 1'b0, 13);
    chk_legal("t5b", 0, 8, 8, 13);
    for (int k = 0; k < 8; k++)
      check($sformatf("t5b mem k%0d", k), mem0[8 + k], (k < 4) ? 8'hAC + 8'(k) : 8'hA0 + 8'(k));

    // RD_LAT=3 single word: write in cycle 6, done in cycle 7
    run(4'd5, 4'd6, 5'd1, 1'b1, 9);
    for (int c = 1; c <= 9; c++) begin
      check($sformatf("t6 busy c%0d", c), busy_l1[c], (c <= 6));
      check($sformatf("t6 done c%0d", c), done_l1[c], (c == 7));
      check($sformatf("t6 b_wr c%0d", c), bwr_l1[c], (c == 6));
      check($sformatf("t6 a_wr c%0d", c), awr_l1[c], 0);
    end
    check("t6 error", err_l1[7], 0);
    check("t6 b_addr", baddr_l1[6], 6);
    check("t6 b_din", bdin_l1[6], 8'hA5);
    check("t6 mem6", mem1[6], 8'hA5);
    check("t6 dut0 idle", busy_l0[3], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
